// File: rtl/fir_coeff_bram_reader_if.sv
// Bundle for the coefficient reader: BRAM port A, coefficient stream and load control.
// The master side is the reader; the slave side is the BRAM plus the FIR.
interface fir_coeff_bram_reader_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic              load_req;
    logic              busy;
    logic              bram_en_a;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wr_data;
    logic [DATA_W-1:0] bram_rd_data;
    logic [DATA_W-1:0] coeff_data;
    logic [ADDR_W-1:0] coeff_idx;
    logic              coeff_valid;
    logic              coeff_ready;
    logic              coeff_commit;

    modport master (
        input  load_req, bram_rd_data, coeff_ready,
        output busy, bram_en_a, bram_we, bram_addr, bram_wr_data,
        output coeff_data, coeff_idx, coeff_valid, coeff_commit
    );

    modport slave (
        output load_req, bram_rd_data, coeff_ready,
        input  busy, bram_en_a, bram_we, bram_addr, bram_wr_data,
        input  coeff_data, coeff_idx, coeff_valid, coeff_commit
    );
endinterface

// File: rtl/fir_coeff_bram_reader.sv
// Streams NUM_COEFFS words from BRAM port A into the FIR shadow bank, then pulses commit.
// Reads are credit-limited so the RD_LAT+2 deep output FIFO can never overflow.
module fir_coeff_bram_reader #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_COEFFS = 1024,
    parameter int unsigned RD_LAT     = 2
) (
    input logic                     clk,
    input logic                     rst,
    fir_coeff_bram_reader_if.master bus
);
    localparam int unsigned FIFO_DEPTH = RD_LAT + 2;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_COEFFS - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StFetch  = 2'd1;
    localparam logic [1:0] StDrain  = 2'd2;
    localparam logic [1:0] StCommit = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

    logic        start;
    logic        fetching;
    logic        issue;
    logic        last_issue;
    logic        push;
    logic        pop;
    logic        last_pop;
    logic        fifo_nonempty;
    int unsigned inflight;

    // The first read goes out in the load_req cycle itself so the first word lands RD_LAT+1 later.
    always_comb begin
        inflight = 0;
        for (int k = 0; k < RD_LAT; k++) begin
            inflight = inflight + 32'(vld_q[k]);
        end
        fifo_nonempty = (fifo_cnt_q != '0);
        start         = (state_q == StIdle) && (bus.load_req || pending_q);
        fetching      = start || (state_q == StFetch);
        issue         = fetching && ((32'(fifo_cnt_q) + inflight) < FIFO_DEPTH);
        last_issue    = issue && (addr_q == LAST_IDX);
        push          = vld_q[RD_LAT-1];
        pop           = fifo_nonempty && bus.coeff_ready;
        last_pop      = pop && (idx_q == LAST_IDX);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = last_issue ? StDrain : StFetch;
            StFetch:  if (last_issue) state_d = StDrain;
            StDrain:  if (last_pop) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        pending_d = pending_q;
        if (start) begin
            pending_d = 1'b0;
        end
        if (bus.load_req && (state_q != StIdle)) begin
            pending_d = 1'b1;
        end

        addr_d = addr_q;
        if (issue) begin
            addr_d = last_issue ? '0 : addr_q + 1'b1;
        end

        idx_d = idx_q;
        if (pop) begin
            idx_d = last_pop ? '0 : idx_q + 1'b1;
        end

        vld_d[0] = issue;
        for (int k = 1; k < RD_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.bram_rd_data;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            pending_q  <= 1'b0;
            addr_q     <= '0;
            idx_q      <= '0;
            vld_q      <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            vld_q      <= vld_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    assign bus.bram_en_a    = issue;
    assign bus.bram_we      = 1'b0;
    assign bus.bram_addr    = addr_q;
    assign bus.bram_wr_data = '0;
    assign bus.coeff_valid  = fifo_nonempty;
    assign bus.coeff_data   = fifo_nonempty ? mem_q[rd_ptr_q] : '0;
    assign bus.coeff_idx    = idx_q;
    assign bus.coeff_commit = (state_q == StCommit);
    assign bus.busy         = (state_q != StIdle);
endmodule

// File: tb/tb_fir_coeff_bram_reader.sv
// Scoreboarded bench: a 16-word/RD_LAT=2 reader for streaming, stall, queueing and reset,
// plus a 1-word/RD_LAT=1 reader for the single-word corner.
module tb_fir_coeff_bram_reader;
    localparam int unsigned AW     = 4;
    localparam int unsigned DW     = 32;
    localparam int unsigned NA     = 16;
    localparam int unsigned LA     = 2;
    localparam int unsigned NB     = 1;
    localparam int unsigned LB     = 1;
    localparam int unsigned FIFO_A = LA + 2;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fir_coeff_bram_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    fir_coeff_bram_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    fir_coeff_bram_reader #(.ADDR_W(AW), .DATA_W(DW), .NUM_COEFFS(NA), .RD_LAT(LA)) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    fir_coeff_bram_reader #(.ADDR_W(AW), .DATA_W(DW), .NUM_COEFFS(NB), .RD_LAT(LB)) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    // BRAM models: output registers keep their last value, so stale data sits on rd_data.
    logic [DW-1:0] ram_a [2**AW];
    logic [DW-1:0] ram_b [2**AW];
    logic [DW-1:0] a_s0 = '0;
    logic [DW-1:0] a_s1 = '0;
    logic [DW-1:0] b_s0 = '0;
    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            ram_a[i] = DW'(i * 3);
            ram_b[i] = DW'(32'h100 + i * 7);
        end
    end
    always @(posedge clk) begin
        if (bus_a.bram_en_a) a_s0 <= ram_a[bus_a.bram_addr];
        a_s1 <= a_s0;
        if (bus_b.bram_en_a) b_s0 <= ram_b[bus_b.bram_addr];
    end
    assign bus_a.bram_rd_data = a_s1;
    assign bus_b.bram_rd_data = b_s0;

    exp_t          sb_a[$];
    int            en_cnt = 0;
    int            hs_cnt = 0;
    int            commit_cnt = 0;
    int            first_valid_cyc = -1;
    int            last_commit_cyc = -1;
    int            last_hs_cyc = -1;
    logic [AW-1:0] exp_addr = '0;
    logic          stalled = 1'b0;
    exp_t          held = '0;

    always @(negedge clk) begin : mon_a
        exp_t e;
        tests++;
        if (bus_a.bram_we !== 1'b0 || bus_a.bram_wr_data !== '0) begin
            fails++;
            $display("FAIL wr_port_a: we=%b wr_data=%h, required 0 and 0",
                     bus_a.bram_we, bus_a.bram_wr_data);
        end
        if (rst) begin
            sb_a.delete();
            stalled  = 1'b0;
            exp_addr = '0;
        end else begin
            tests++;
            if (int'(dut_a.fifo_cnt_q) > FIFO_A) begin
                fails++;
                $display("FAIL fifo_occupancy: %0d, required <= %0d", dut_a.fifo_cnt_q, FIFO_A);
            end
            if (bus_a.bram_en_a) begin
                en_cnt++;
                tests++;
                if (bus_a.bram_addr !== exp_addr) begin
                    fails++;
                    $display("FAIL issue_addr: %0d, required %0d", bus_a.bram_addr, exp_addr);
                end
                exp_addr = (exp_addr == AW'(NA - 1)) ? '0 : exp_addr + 1'b1;
            end
            if (stalled) begin
                tests++;
                if (bus_a.coeff_valid !== 1'b1 || bus_a.coeff_idx !== held.idx ||
                    bus_a.coeff_data !== held.data) begin
                    fails++;
                    $display("FAIL stall_hold: valid=%b idx=%0d data=%0d, required 1 %0d %0d",
                             bus_a.coeff_valid, bus_a.coeff_idx, bus_a.coeff_data,
                             held.idx, held.data);
                end
            end
            stalled = bus_a.coeff_valid && !bus_a.coeff_ready;
            held    = {bus_a.coeff_idx, bus_a.coeff_data};
            if (bus_a.coeff_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus_a.coeff_valid && bus_a.coeff_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                tests++;
                if (sb_a.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: idx=%0d data=%0d, required none",
                             bus_a.coeff_idx, bus_a.coeff_data);
                end else begin
                    e = sb_a.pop_front();
                    if (bus_a.coeff_idx !== e.idx || bus_a.coeff_data !== e.data) begin
                        fails++;
                        $display("FAIL word: idx=%0d data=%0d, required idx=%0d data=%0d",
                                 bus_a.coeff_idx, bus_a.coeff_data, e.idx, e.data);
                    end
                end
            end
            if (bus_a.coeff_commit) begin
                commit_cnt++;
                last_commit_cyc = cyc;
                tests++;
                if (last_hs_cyc != cyc - 1) begin
                    fails++;
                    $display("FAIL commit_after_last: last handshake cycle %0d, required %0d",
                             last_hs_cyc, cyc - 1);
                end
            end
        end
    end

    task automatic push_load_a();
        for (int i = 0; i < NA; i++) sb_a.push_back({AW'(i), DW'(i * 3)});
    endtask

    task automatic pulse_load_a(output int t0);
        @(posedge clk);
        #1;
        bus_a.load_req = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        bus_a.load_req = 1'b0;
    endtask

    task automatic wait_commits(input int target, input int budget, input bit rnd,
                                input string name);
        int n = 0;
        while (commit_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            if (rnd) bus_a.coeff_ready = 1'($urandom_range(0, 1));
            n++;
        end
        bus_a.coeff_ready = 1'b1;
        tests++;
        if (commit_cnt < target) begin
            fails++;
            $display("FAIL %s_timeout: commits=%0d, required %0d", name, commit_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests += 8;
        if (bus_a.bram_en_a !== 1'b0) begin
            fails++; $display("FAIL rst_en: %b, required 0", bus_a.bram_en_a);
        end
        if (bus_a.bram_addr !== '0) begin
            fails++; $display("FAIL rst_addr: %0d, required 0", bus_a.bram_addr);
        end
        if (bus_a.coeff_valid !== 1'b0) begin
            fails++; $display("FAIL rst_valid: %b, required 0", bus_a.coeff_valid);
        end
        if (bus_a.coeff_data !== '0) begin
            fails++; $display("FAIL rst_data: %h, required 0", bus_a.coeff_data);
        end
        if (bus_a.coeff_idx !== '0) begin
            fails++; $display("FAIL rst_idx: %0d, required 0", bus_a.coeff_idx);
        end
        if (bus_a.coeff_commit !== 1'b0) begin
            fails++; $display("FAIL rst_commit: %b, required 0", bus_a.coeff_commit);
        end
        if (bus_a.busy !== 1'b0) begin
            fails++; $display("FAIL rst_busy: %b, required 0", bus_a.busy);
        end
        if ({bus_b.busy, bus_b.coeff_valid, bus_b.bram_en_a} !== 3'b000) begin
            fails++;
            $display("FAIL rst_b: busy/valid/en=%b%b%b, required 000",
                     bus_b.busy, bus_b.coeff_valid, bus_b.bram_en_a);
        end
    endtask

    task automatic test_stream();
        int t0;
        int en0 = en_cnt;
        int hs0 = hs_cnt;
        int c0  = commit_cnt;
        first_valid_cyc = -1;
        push_load_a();
        pulse_load_a(t0);
        @(negedge clk);
        tests++;
        if (bus_a.busy !== 1'b1) begin
            fails++; $display("FAIL stream_busy_high: %b, required 1", bus_a.busy);
        end
        wait_commits(c0 + 1, 60, 1'b0, "stream");
        @(negedge clk);
        tests += 6;
        if (bus_a.busy !== 1'b0) begin
            fails++; $display("FAIL stream_busy_low: %b, required 0", bus_a.busy);
        end
        if (first_valid_cyc != t0 + 3) begin
            fails++;
            $display("FAIL stream_first_valid: cycle %0d, required %0d", first_valid_cyc, t0 + 3);
        end
        if (last_commit_cyc != t0 + 19) begin
            fails++;
            $display("FAIL stream_commit: cycle %0d, required %0d", last_commit_cyc, t0 + 19);
        end
        if (en_cnt - en0 != NA) begin
            fails++; $display("FAIL stream_en_count: %0d, required %0d", en_cnt - en0, NA);
        end
        if (hs_cnt - hs0 != NA) begin
            fails++; $display("FAIL stream_words: %0d, required %0d", hs_cnt - hs0, NA);
        end
        if (sb_a.size() != 0) begin
            fails++; $display("FAIL stream_left: %0d, required 0", sb_a.size());
        end
    endtask

    task automatic test_random_ready();
        int t0;
        int en0 = en_cnt;
        int hs0 = hs_cnt;
        int c0  = commit_cnt;
        push_load_a();
        pulse_load_a(t0);
        wait_commits(c0 + 1, 300, 1'b1, "random");
        repeat (4) @(negedge clk);
        tests += 4;
        if (commit_cnt - c0 != 1) begin
            fails++; $display("FAIL random_commits: %0d, required 1", commit_cnt - c0);
        end
        if (en_cnt - en0 != NA) begin
            fails++; $display("FAIL random_en_count: %0d, required %0d", en_cnt - en0, NA);
        end
        if (hs_cnt - hs0 != NA) begin
            fails++; $display("FAIL random_words: %0d, required %0d", hs_cnt - hs0, NA);
        end
        if (sb_a.size() != 0) begin
            fails++; $display("FAIL random_left: %0d, required 0", sb_a.size());
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        int en0 = en_cnt;
        int hs0 = hs_cnt;
        int c0  = commit_cnt;
        push_load_a();
        pulse_load_a(t0);
        repeat (3) @(posedge clk);
        pulse_load_a(t1);
        repeat (2) @(posedge clk);
        pulse_load_a(t1);
        push_load_a();
        wait_commits(c0 + 2, 150, 1'b0, "b2b");
        repeat (30) @(negedge clk);
        tests += 5;
        if (commit_cnt - c0 != 2) begin
            fails++; $display("FAIL b2b_commits: %0d, required 2", commit_cnt - c0);
        end
        if (en_cnt - en0 != 2 * NA) begin
            fails++; $display("FAIL b2b_en_count: %0d, required %0d", en_cnt - en0, 2 * NA);
        end
        if (hs_cnt - hs0 != 2 * NA) begin
            fails++; $display("FAIL b2b_words: %0d, required %0d", hs_cnt - hs0, 2 * NA);
        end
        if (sb_a.size() != 0) begin
            fails++; $display("FAIL b2b_left: %0d, required 0", sb_a.size());
        end
        if (bus_a.busy !== 1'b0) begin
            fails++; $display("FAIL b2b_busy_low: %b, required 0", bus_a.busy);
        end
    endtask

    task automatic test_commit_coincident();
        int t0;
        int c0 = commit_cnt;
        push_load_a();
        push_load_a();
        pulse_load_a(t0);
        while (cyc < t0 + 19) begin
            @(posedge clk);
            #1;
        end
        bus_a.load_req = 1'b1;
        @(posedge clk);
        #1;
        bus_a.load_req = 1'b0;
        wait_commits(c0 + 2, 100, 1'b0, "coincident");
        @(negedge clk);
        tests += 2;
        if (last_commit_cyc != t0 + 39) begin
            fails++;
            $display("FAIL coincident_commit: cycle %0d, required %0d", last_commit_cyc, t0 + 39);
        end
        if (sb_a.size() != 0) begin
            fails++; $display("FAIL coincident_left: %0d, required 0", sb_a.size());
        end
    endtask

    task automatic test_reset_midload();
        int t0;
        int n = 0;
        int c0 = commit_cnt;
        int en0;
        int hs0;
        push_load_a();
        pulse_load_a(t0);
        while (!(bus_a.coeff_valid === 1'b1 && bus_a.coeff_idx === AW'(7)) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++; $display("FAIL midrst_reach_word7: timeout, required idx 7");
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({bus_a.bram_en_a, bus_a.bram_addr, bus_a.coeff_valid, bus_a.coeff_data,
             bus_a.coeff_idx, bus_a.coeff_commit, bus_a.busy} !== '0) begin
            fails++;
            $display("FAIL midrst_outputs: valid=%b idx=%0d data=%0d busy=%b, required all 0",
                     bus_a.coeff_valid, bus_a.coeff_idx, bus_a.coeff_data, bus_a.busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        tests++;
        if (commit_cnt != c0) begin
            fails++; $display("FAIL midrst_no_commit: %0d, required %0d", commit_cnt, c0);
        end
        en0 = en_cnt;
        hs0 = hs_cnt;
        push_load_a();
        pulse_load_a(t0);
        wait_commits(c0 + 1, 60, 1'b0, "midrst");
        repeat (2) @(negedge clk);
        tests += 3;
        if (hs_cnt - hs0 != NA) begin
            fails++; $display("FAIL midrst_words: %0d, required %0d", hs_cnt - hs0, NA);
        end
        if (en_cnt - en0 != NA) begin
            fails++; $display("FAIL midrst_en_count: %0d, required %0d", en_cnt - en0, NA);
        end
        if (sb_a.size() != 0) begin
            fails++; $display("FAIL midrst_left: %0d, required 0", sb_a.size());
        end
    endtask

    task automatic test_single();
        exp_t q[$];
        exp_t e;
        int t0;
        int en = 0;
        int hs = 0;
        int cm = -1;
        int fv = -1;
        q.push_back({AW'(0), DW'(32'h100)});
        @(posedge clk);
        #1;
        bus_b.load_req = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tests++;
            if (bus_b.bram_we !== 1'b0 || bus_b.bram_wr_data !== '0) begin
                fails++;
                $display("FAIL wr_port_b: we=%b wr_data=%h, required 0 and 0",
                         bus_b.bram_we, bus_b.bram_wr_data);
            end
            if (bus_b.bram_en_a) begin
                en++;
                tests++;
                if (bus_b.bram_addr !== '0) begin
                    fails++; $display("FAIL single_addr: %0d, required 0", bus_b.bram_addr);
                end
            end
            if (bus_b.coeff_valid && bus_b.coeff_ready) begin
                hs++;
                if (fv < 0) fv = cyc;
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL single_extra_word: idx=%0d, required none",
                                      bus_b.coeff_idx);
                end else begin
                    e = q.pop_front();
                    if (bus_b.coeff_idx !== e.idx || bus_b.coeff_data !== e.data) begin
                        fails++;
                        $display("FAIL single_word: idx=%0d data=%h, required idx=%0d data=%h",
                                 bus_b.coeff_idx, bus_b.coeff_data, e.idx, e.data);
                    end
                end
            end
            if (bus_b.coeff_commit) cm = cyc;
            @(posedge clk);
            #1;
            bus_b.load_req = 1'b0;
        end
        tests += 4;
        if (cm != t0 + 3) begin
            fails++; $display("FAIL single_commit: cycle %0d, required %0d", cm, t0 + 3);
        end
        if (fv != t0 + 2) begin
            fails++; $display("FAIL single_first_valid: cycle %0d, required %0d", fv, t0 + 2);
        end
        if (en != 1) begin
            fails++; $display("FAIL single_en_count: %0d, required 1", en);
        end
        if (hs != 1 || q.size() != 0) begin
            fails++; $display("FAIL single_words: %0d, required 1", hs);
        end
    endtask

    initial begin
        bus_a.load_req    = 1'b0;
        bus_a.coeff_ready = 1'b1;
        bus_b.load_req    = 1'b0;
        bus_b.coeff_ready = 1'b1;
        test_reset();
        test_stream();
        test_random_ready();
        test_back_to_back();
        test_commit_coincident();
        test_reset_midload();
        test_single();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at 300000, required finish earlier");
        $fatal(1, "watchdog expired");
    end
endmodule
